// File: rtl/fixed_sub_seq_if.sv
// Operand/result stream bundle for the digit-serial fixed-point subtractor.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface fixed_sub_seq_if #(
    parameter int data_width = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [data_width-1:0] A_in;
    logic [data_width-1:0] B_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [data_width-1:0] out;
    logic                  overflow_flag;
    logic                  underflow_flag;

    // Subtractor side: consumes operands, produces the result.
    modport slave (
        input  in_valid, A_in, B_in, out_ready,
        output in_ready, out_valid, out, overflow_flag, underflow_flag
    );

    // Producer/consumer side.
    modport master (
        output in_valid, A_in, B_in, out_ready,
        input  in_ready, out_valid, out, overflow_flag, underflow_flag
    );
endinterface

// File: rtl/fixed_sub_seq.sv
// Signed fixed-point OUT = A - B (Q2.14 default), one digit per clock LSB first with a borrow chain.
// Latency: data_width/digit_width clocks from the accepting edge to out_valid; no overlap (II = N+2).
// Backpressure: in_ready only in IDLE; result, flags and out_valid hold while out_ready is low.
// Optional: define FIXED_SUB_SATURATE_EN to clamp out to max/min on overflow/underflow.
module fixed_sub_seq #(
    parameter int data_width  = 16,
    parameter int frac_width  = 14,
    parameter int int_width   = 2,
    parameter int digit_width = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    fixed_sub_seq_if.slave    bus_if
);
    localparam int N     = data_width / digit_width;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0]      LAST    = CNT_W'(N - 1);
    localparam logic [data_width-1:0] MAX_POS = {1'b0, {(data_width-1){1'b1}}};
    localparam logic [data_width-1:0] MAX_NEG = {1'b1, {(data_width-1){1'b0}}};

    // Reject inconsistent number formats at elaboration time.
    if (int_width + frac_width != data_width) begin : g_bad_format
        $error("fixed_sub_seq: int_width + frac_width must equal data_width");
    end
    if ((data_width % digit_width) != 0 || N < 2) begin : g_bad_digit
        $error("fixed_sub_seq: digit_width must divide data_width into at least two digits");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic [data_width-1:0] a_q, a_d;       // minuend, shifted right one digit per cycle
    logic [data_width-1:0] b_q, b_d;       // subtrahend, shifted likewise
    logic [data_width-1:0] res_q, res_d;   // result digits enter at the top
    logic [data_width-1:0] out_q, out_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  borrow_q, borrow_d;
    logic                  sa_q, sa_d;     // operand signs kept aside since a_q/b_q get shifted
    logic                  sb_q, sb_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic [digit_width:0]  diff;
    logic [data_width-1:0] full_res;
    logic                  sr;
    logic                  ovf_n;
    logic                  udf_n;

    // Current digit difference and the result as it would stand after this digit.
    always_comb begin
        diff     = {1'b0, a_q[digit_width-1:0]} - {1'b0, b_q[digit_width-1:0]}
                   - (digit_width+1)'(borrow_q);
        full_res = {diff[digit_width-1:0], res_q[data_width-1:digit_width]};
        sr       = full_res[data_width-1];
        ovf_n    = ~sa_q & sb_q & sr;
        udf_n    = sa_q & ~sb_q & ~sr;
    end

    // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        case (state_q)
            IDLE: begin
                if (bus_if.in_valid) begin
                    a_d      = bus_if.A_in;
                    b_d      = bus_if.B_in;
                    sa_d     = bus_if.A_in[data_width-1];
                    sb_d     = bus_if.B_in[data_width-1];
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                a_d      = a_q >> digit_width;
                b_d      = b_q >> digit_width;
                res_d    = full_res;
                borrow_d = diff[digit_width];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    ovf_d   = ovf_n;
                    udf_d   = udf_n;
`ifdef FIXED_SUB_SATURATE_EN
                    if (ovf_n)
                        out_d = MAX_POS;
                    else if (udf_n)
                        out_d = MAX_NEG;
                    else
                        out_d = full_res;
`else
                    out_d = full_res;
`endif
                end
            end
            DONE: begin
                if (bus_if.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign bus_if.in_ready       = (state_q == IDLE);
    assign bus_if.out_valid      = (state_q == DONE);
    assign bus_if.out            = out_q;
    assign bus_if.overflow_flag  = ovf_q;
    assign bus_if.underflow_flag = udf_q;

    // Sign bits reach the flags through sa_q/sb_q; the top of MAX_NEG/MAX_POS are constants.
    logic unused_ok;
    assign unused_ok = ^{MAX_POS, MAX_NEG};
endmodule

// File: tb/tb_fixed_sub_seq.sv
// Directed bench for fixed_sub_seq: vector table plus back-pressure and reset-abort sequences.
// Inputs are driven 1 time unit after the rising edge and outputs are checked there too.
module tb_fixed_sub_seq;
`ifdef FIXED_SUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    fixed_sub_seq_if #(.data_width(16)) bus ();

    fixed_sub_seq #(
        .data_width(16), .frac_width(14), .int_width(2), .digit_width(4)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus_if  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] wrapped;
        logic        ovf;
        logic        udf;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_out(input logic [15:0] w, input logic o, input logic u);
        if (SAT && o) return 16'h7FFF;
        if (SAT && u) return 16'h8000;
        return w;
    endfunction

    // Wait up to a bounded number of cycles for out_valid; returns cycles waited.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.out_valid && cyc < 20);
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] w, input logic o, input logic u);
        int cyc;
        check({name, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
        bus.A_in      = a;
        bus.B_in      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.A_in     = ~a;
        bus.B_in     = ~b;
        wait_valid(cyc);
        check({name, " latency"}, 32'(cyc), 32'd4);
        check({name, " out"}, 32'(bus.out), 32'(exp_out(w, o, u)));
        check({name, " ovf"}, 32'(bus.overflow_flag), 32'(o));
        check({name, " udf"}, 32'(bus.underflow_flag), 32'(u));
        tick();
        check({name, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
        check({name, " in_ready back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int cyc;
        int seen;
        vecs[0]  = '{16'h4000, 16'h2000, 16'h2000, 1'b0, 1'b0};
        vecs[1]  = '{16'h7000, 16'hC000, 16'hB000, 1'b1, 1'b0};
        vecs[2]  = '{16'h9000, 16'h4000, 16'h5000, 1'b0, 1'b1};
        vecs[3]  = '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b0};
        vecs[4]  = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{16'h1234, 16'h0111, 16'h1123, 1'b0, 1'b0};
        vecs[6]  = '{16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
        vecs[7]  = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
        vecs[8]  = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0};
        vecs[9]  = '{16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{16'hFFFF, 16'h7FFF, 16'h8000, 1'b0, 1'b0};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A_in      = '0;
        bus.B_in      = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check("reset out", 32'(bus.out), 32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset ovf", 32'(bus.overflow_flag), 32'd0);
        check("reset udf", 32'(bus.underflow_flag), 32'd0);
        reset = 1'b0;
        tick();
        check("in_ready after reset", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].wrapped, vecs[i].ovf, vecs[i].udf);

        // Back-pressure: hold the result three cycles while new operands are offered.
        bus.out_ready = 1'b0;
        bus.A_in      = 16'h7000;
        bus.B_in      = 16'hC000;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_valid(cyc);
        check("bp latency", 32'(cyc), 32'd4);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.A_in     = 16'h0001;
            bus.B_in     = 16'h0002;
            tick();
            check("bp out_valid held", 32'(bus.out_valid), 32'd1);
            check("bp out held", 32'(bus.out), 32'(exp_out(16'hB000, 1'b1, 1'b0)));
            check("bp ovf held", 32'(bus.overflow_flag), 32'd1);
            check("bp udf held", 32'(bus.underflow_flag), 32'd0);
            check("bp in_ready low", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp out_valid drop", 32'(bus.out_valid), 32'd0);
        check("bp in_ready back", 32'(bus.in_ready), 32'd1);
        check("bp out kept after handshake", 32'(bus.out), 32'(exp_out(16'hB000, 1'b1, 1'b0)));
        check("bp ovf kept after handshake", 32'(bus.overflow_flag), 32'd1);
        run_op("bp next", 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0);

        // Reset two clocks into an operation aborts it with no partial result.
        bus.A_in     = 16'h1234;
        bus.B_in     = 16'h0111;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort out", 32'(bus.out), 32'd0);
        check("abort ovf", 32'(bus.overflow_flag), 32'd0);
        check("abort udf", 32'(bus.underflow_flag), 32'd0);
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("abort no out_valid", 32'(seen), 32'd0);
        run_op("after abort", 16'h1234, 16'h0111, 16'h1123, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fixed_sub_seq.md
Name: fixed_sub_seq

Overview:
- Multi-cycle signed fixed-point subtractor, default Q2.14, computing OUT = A - B.
- Mirror operation of the team's fixed-point adder and shares its number format and overflow/underflow flag semantics.
- Processes the operands digit-serially, least significant digit first, with a borrow chain, to keep area small.
- Uses valid/ready handshakes on the input and output sides so it can sit between streaming stages of the datapath.

Parameters:
- data_width, 16, total word width in bits.
- frac_width, 14, number of fractional bits.
- int_width, 2, number of integer bits including sign; int_width + frac_width must equal data_width.
- digit_width, 4, bits processed per cycle; must divide data_width. N = data_width/digit_width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- A_in  in  data_width  signed minuend.
- B_in  in  data_width  signed subtrahend.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out  out  data_width  signed result, registered.
- overflow_flag  out  1  positive overflow.
- underflow_flag  out  1  negative overflow.

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, out=0, out_valid=0, overflow_flag=0, underflow_flag=0, digit counter=0, borrow=0. in_ready reads 1 on the first cycle after reset deasserts.
- in_ready = (state==IDLE). It is never high in BUSY or DONE.
- State IDLE:
  - On in_valid && in_ready, capture A_in and B_in into operand registers, clear borrow and the counter, and go to BUSY.
  - in_valid while not ready is ignored; upstream must hold its data.
- State BUSY, one digit per cycle, LSB digit first, counter k=0..N-1:
  - diff = a_dig - b_dig - borrow, computed digit_width+1 bits wide.
  - Result digit = diff[digit_width-1:0].
  - borrow_next = diff[digit_width], i.e. a borrow out of the digit.
  - Result digits shift into a result register.
  - After digit N-1 the state goes to DONE.
- Latency: exactly N clocks from the accepting edge to out_valid=1 (4 with defaults).
- Flags, evaluated on the edge that enters DONE, from the captured operand sign bits sa and sb and the raw result sign sr:
  - overflow_flag = ~sa & sb & sr (positive minus negative gives a negative result).
  - underflow_flag = sa & ~sb & ~sr (negative minus positive gives a positive result).
  - The two flags are mutually exclusive.
- out, overflow_flag and underflow_flag load on entry to DONE and hold stable until the next result loads. They are not cleared on the output handshake.
- State DONE:
  - out_valid=1.
  - On out_ready=1: out_valid goes 0 on the next edge and the state returns to IDLE, so in_ready=1 one cycle after the output handshake.
  - While out_ready=0, out_valid, out and the flags are held unchanged indefinitely.
- Minimum initiation interval is N+2 cycles. The block has no overlap between operations.
- reset asserted in any state, including mid-BUSY, aborts the operation. All outputs return to their reset values on that edge and no partial result is ever presented.
- Edge cases:
  - A == B gives out=0 with no flags.
  - Most-negative operand cases follow the same flag rules with no special-casing. Example: 0x0000 - 0x8000 sets overflow.

Optional Feature:
- Macro: FIXED_SUB_SATURATE_EN.
- Defined: when overflow_flag is set, out is clamped to the maximum positive value (0x7FFF at defaults). When underflow_flag is set, out is clamped to the most-negative value (0x8000). Flags and timing are unchanged.
- Undefined: out is the wrapped two's-complement result.

Test Plan:
1. Reset, then A=0x4000 (1.0), B=0x2000 (0.5), out_ready=1 -> out_valid high exactly 4 clocks after the accepting edge, out=0x2000, both flags 0, in_ready=1 the cycle after the output handshake.
2. A=0x7000 (1.75), B=0xC000 (-1.0) -> overflow_flag=1, underflow_flag=0. out=0xB000 without FIXED_SUB_SATURATE_EN; out=0x7FFF with it.
3. A=0x9000 (-1.75), B=0x4000 (1.0) -> underflow_flag=1, overflow_flag=0. out=0x5000 wrapped; out=0x8000 saturated.
4. A=0x0000, B=0x8000 -> overflow_flag=1. out=0x8000 wrapped; 0x7FFF saturated.
5. Back-pressure: complete an operation with out_ready=0 for 3 cycles, then raise it. Pulse in_valid with new operands during the hold -> out, flags and out_valid stay stable, in_ready stays 0, new operands are not taken, and they are accepted only after returning to IDLE.
6. Assert reset for one cycle two clocks after accepting A=0x1234, B=0x0111 -> out=0, flags 0, out_valid never asserts, in_ready=1 after reset. A following A=0x1234, B=0x0111 yields out=0x1123.
